ac97_cmd_scheduler: RTL and testbench
=====================================

// Module: ac97_cmd_scheduler
// PURPOSE
//  Sequences all AC97 codec register writes on the system clock: holds the codec in reset, waits for codec
//  ready, and plays a fixed init table. It then shares the command slot between two requesters: the volume
//  control (GPIO_DIP[5:2]) and a generic external write port (e.g. a UART debug path).
//  It feeds the AC97 controller's command input through a valid/ready handshake and drives FLASH_AUDIO_RESET_B.
// PARAMETERS
//  RESET_HOLD_CYCLES      1_000          cycles codec_reset_b is held low per reset attempt
//  POWERUP_TIMEOUT_CYCLES 33_000_000     cycles to wait for codec_ready before retrying reset
// PORTS
//  clk             in   1   system clock (CLK_33MHZ_FPGA)
//  reset_b         in   1   asynchronous, active-low reset
//  codec_ready     in   1   slot-0 codec-ready bit, bit_clk domain; 2-flop synchronised internally
//  volume_control  in   4   requested volume, 0 = mute, 15 = loudest
//  reinit          in   1   one-cycle pulse: rerun full reset/init sequence
//  ext_req         in   1   external write request (level); ext_addr/ext_data stable while high
//  ext_addr        in   7   external register address
//  ext_data        in   16  external register data
//  ext_ack         out  1   one-cycle pulse: external write transferred
//  cmd_valid       out  1   command present on cmd_addr/cmd_data
//  cmd_addr        out  7   codec register address
//  cmd_data        out  16  codec register data
//  cmd_ready       in   1   controller accepts command this cycle
//  codec_reset_b   out  1   codec reset, active-low (to IOB flop)
//  init_done       out  1   init table completed; stays high until reset_b/reinit
//  init_error      out  1   sticky: at least one power-up timeout since reset_b
// BEHAVIOUR
//  - Reset values: cmd_valid=0, cmd_addr=0, cmd_data=0, codec_reset_b=0, init_done=0, init_error=0, ext_ack=0;
//    FSM in HOLD with hold counter 0. Async reset mid-transfer drops the command; nothing is retried.
//  - Handshake: transfer on a cycle with cmd_valid && cmd_ready. addr/data are registered and do not change
//    while cmd_valid=1 and no transfer. The next command may be presented the cycle after a transfer.
//    No combinational path exists from cmd_ready to cmd_valid.
//  - FSM states:
//    HOLD   codec_reset_b=0 for exactly RESET_HOLD_CYCLES cycles -> WAIT.
//    WAIT   codec_reset_b=1; synced codec_ready=1 -> INIT (idx=0).
//           Otherwise after POWERUP_TIMEOUT_CYCLES: set init_error -> HOLD.
//    INIT   present table[idx]; on transfer idx++; after idx 3 transfers -> IDLE, init_done=1 same edge.
//    IDLE   arbitrate pending requests, vol > ext (fixed priority), -> VOL0 or EXT.
//    VOL0/VOL1  write 0x02 then 0x04 with vol_word(vol_snap) -> IDLE.
//    EXT    present ext_addr/ext_data; on transfer ext_ack=1 next cycle -> IDLE.
//  - Init table: (0x00,0x0000) (0x02,vol_word) (0x04,vol_word) (0x18,0x0808).
//    vol_snap is captured on entering INIT.
//  - vol_word(v): v==0 -> 0x8000; else a=2*(15-v) (5b, 0..28), word={3'b0,a,3'b0,a}.
//  - Volume pending: volume_control != last_sent. vol_snap is latched on leaving IDLE for VOL0.
//    last_sent updates after the VOL1 transfer. A change during VOL0/VOL1 produces a further round.
//    A change during INIT is serviced from IDLE afterwards.
//  - ext_req is ignored outside IDLE (held off, no ack). ext_ack is never asserted for a transfer
//    that did not complete.
//  - reinit is honoured only in IDLE (deferred while in VOL*/EXT). It clears init_done and goes to HOLD.
//    Pulses in HOLD/WAIT/INIT are ignored.
//  - Counters saturate at their limits; no wrap.
// CONFIGURATION
//  AC97_SCHED_RR_EN defined: IDLE arbitration is round-robin between vol and ext. The winner of the last
//    grant has lowest priority next; the first grant after reset goes to vol.
//  Undefined: fixed priority, vol > ext.
// TESTING
//  1 RESET_HOLD_CYCLES=4, release reset_b -> codec_reset_b low exactly 4 clk after release, then high.
//  2 volume=4'hF, codec_ready=1, cmd_ready=1 -> transfers (00,0000)(02,0000)(04,0000)(18,0808);
//    init_done rises on the last.
//  3 cmd_ready=0 for 10 cycles at init idx 1 -> cmd_valid=1, (02,0000) stable all 10 cycles, single transfer.
//  4 In IDLE, volume F->0 -> (02,8000)(04,8000); then volume 8 -> (02,0E0E)(04,0E0E).
//  5 ext_req (0x1A,0x0404) in the same cycle as a volume change -> vol pair first, then (1A,0404).
//    ext_ack is a 1-cycle pulse.
//    RR_EN with both continuously pending -> grants alternate vol, ext, vol.
//  6 POWERUP_TIMEOUT_CYCLES=20, codec_ready=0 -> init_error=1 after 20 WAIT cycles, codec_reset_b low again.
//    Raise codec_ready -> init completes, init_error stays 1.

Source files
------------

// File: rtl/ac97_cmd_scheduler.sv
// AC97 codec command scheduler: reset/power-up sequencing, init table, then volume/external write arbitration.
// Define AC97_SCHED_RR_EN for round-robin arbitration between volume and external writes (default: volume first).
module ac97_cmd_scheduler #(
    parameter int RESET_HOLD_CYCLES      = 1_000,
    parameter int POWERUP_TIMEOUT_CYCLES = 33_000_000
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        codec_ready,
    input  logic [3:0]  volume_control,
    input  logic        reinit,
    input  logic        ext_req,
    input  logic [6:0]  ext_addr,
    input  logic [15:0] ext_data,
    output logic        ext_ack,
    output logic        cmd_valid,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    input  logic        cmd_ready,
    output logic        codec_reset_b,
    output logic        init_done,
    output logic        init_error
);
    // state | meaning
    // HOLD  | codec held in reset for RESET_HOLD_CYCLES
    // WAIT  | codec released, waiting for synced codec_ready or timeout
    // INIT  | playing the four-entry init table
    // IDLE  | arbitrating volume / external / reinit
    // VOL0  | writing master volume (0x02)
    // VOL1  | writing headphone volume (0x04)
    // EXT   | forwarding one external write
    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_INIT, S_IDLE, S_VOL0, S_VOL1, S_EXT} state_t;

    localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD_CYCLES - 1);
    localparam logic [31:0] WAIT_LAST = 32'(POWERUP_TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic [31:0] cnt;
    logic [1:0]  idx;
    logic        ready_meta, ready_sync;
    logic [3:0]  vol_snap, last_sent;
    logic        reinit_pend;
    logic        rr_last_vol;
    logic        xfer, vol_pend, grant_vol;
    logic        load, drop;
    logic [6:0]  ld_addr;
    logic [15:0] ld_data;

    function automatic logic [15:0] vol_word(input logic [3:0] v);
        logic [4:0] a;
        a = 5'd30 - {v, 1'b0};
        return (v == 4'd0) ? 16'h8000 : {3'b000, a, 3'b000, a};
    endfunction

    assign xfer     = cmd_valid && cmd_ready;
    assign vol_pend = volume_control != last_sent;
`ifdef AC97_SCHED_RR_EN
    assign grant_vol = vol_pend && (!ext_req || !rr_last_vol);
`else
    assign grant_vol = vol_pend;
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        ld_addr    = 7'h00;
        ld_data    = 16'h0000;
        case (state)
            S_HOLD: if (cnt == HOLD_LAST) state_next = S_WAIT;
            S_WAIT: begin
                if (ready_sync) begin
                    state_next = S_INIT;
                    load       = 1'b1;
                end else if (cnt == WAIT_LAST) begin
                    state_next = S_HOLD;
                end
            end
            S_INIT: begin
                if (xfer) begin
                    if (idx == 2'd3) begin
                        state_next = S_IDLE;
                        drop       = 1'b1;
                    end else begin
                        load = 1'b1;
                        case (idx)
                            2'd0:    begin ld_addr = 7'h02; ld_data = vol_word(vol_snap); end
                            2'd1:    begin ld_addr = 7'h04; ld_data = vol_word(vol_snap); end
                            default: begin ld_addr = 7'h18; ld_data = 16'h0808; end
                        endcase
                    end
                end
            end
            S_IDLE: begin
                if (reinit || reinit_pend) begin
                    state_next = S_HOLD;
                end else if (grant_vol) begin
                    state_next = S_VOL0;
                    load       = 1'b1;
                    ld_addr    = 7'h02;
                    ld_data    = vol_word(volume_control);
                end else if (ext_req) begin
                    state_next = S_EXT;
                    load       = 1'b1;
                    ld_addr    = ext_addr;
                    ld_data    = ext_data;
                end
            end
            S_VOL0: begin
                if (xfer) begin
                    state_next = S_VOL1;
                    load       = 1'b1;
                    ld_addr    = 7'h04;
                    ld_data    = vol_word(vol_snap);
                end
            end
            S_VOL1, S_EXT: begin
                if (xfer) begin
                    state_next = S_IDLE;
                    drop       = 1'b1;
                end
            end
            default: state_next = S_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state         <= S_HOLD;
            cnt           <= 32'd0;
            idx           <= 2'd0;
            ready_meta    <= 1'b0;
            ready_sync    <= 1'b0;
            vol_snap      <= 4'd0;
            last_sent     <= 4'd0;
            reinit_pend   <= 1'b0;
            rr_last_vol   <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_addr      <= 7'h00;
            cmd_data      <= 16'h0000;
            codec_reset_b <= 1'b0;
            init_done     <= 1'b0;
            init_error    <= 1'b0;
            ext_ack       <= 1'b0;
        end else begin
            state         <= state_next;
            ready_meta    <= codec_ready;
            ready_sync    <= ready_meta;
            codec_reset_b <= state_next != S_HOLD;
            ext_ack       <= (state == S_EXT) && xfer;
            if (state_next != state) cnt <= 32'd0;
            else if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;

            if (load) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= ld_addr;
                cmd_data  <= ld_data;
            end else if (drop) begin
                cmd_valid <= 1'b0;
            end

            if (state == S_WAIT && state_next == S_HOLD) init_error <= 1'b1;
            if (state == S_WAIT && state_next == S_INIT) begin
                idx      <= 2'd0;
                vol_snap <= volume_control;
            end
            if (state == S_INIT && xfer) begin
                if (idx != 2'd3) idx <= idx + 2'd1;
                else begin
                    init_done <= 1'b1;
                    last_sent <= vol_snap;
                end
            end
            if (state == S_VOL1 && xfer) last_sent <= vol_snap;

            if (state == S_IDLE) begin
                case (state_next)
                    S_HOLD: begin
                        init_done   <= 1'b0;
                        reinit_pend <= 1'b0;
                    end
                    S_VOL0: begin
                        vol_snap    <= volume_control;
                        rr_last_vol <= 1'b1;
                    end
                    S_EXT:   rr_last_vol <= 1'b0;
                    default: ;
                endcase
            end else if (reinit && (state == S_VOL0 || state == S_VOL1 || state == S_EXT)) begin
                reinit_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Self-checking bench for ac97_cmd_scheduler: directed sequencing steps plus randomized volume/external traffic.
module tb_ac97_cmd_scheduler;
    localparam int HOLD_N = 4;
    localparam int TO_N   = 20;
`ifdef AC97_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        codec_ready = 1'b0;
    logic [3:0]  volume_control = 4'hF;
    logic        reinit = 1'b0;
    logic        ext_req = 1'b0;
    logic [6:0]  ext_addr = 7'h00;
    logic [15:0] ext_data = 16'h0000;
    logic        cmd_ready = 1'b0;
    logic        ext_ack, cmd_valid, codec_reset_b, init_done, init_error;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;

    always #5 clk = ~clk;

    ac97_cmd_scheduler #(.RESET_HOLD_CYCLES(HOLD_N), .POWERUP_TIMEOUT_CYCLES(TO_N)) dut (
        .clk(clk), .reset_b(reset_b), .codec_ready(codec_ready), .volume_control(volume_control),
        .reinit(reinit), .ext_req(ext_req), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ack(ext_ack),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .codec_reset_b(codec_reset_b), .init_done(init_done), .init_error(init_error)
    );

    int          checks = 0;
    int          errors = 0;
    int          ack_cnt = 0;
    int          exp_acks = 0;
    bit          rdy_rand = 1'b0;
    bit          tb_last_vol = 1'b0;
    logic [3:0]  model_vol = 4'hF;
    logic [22:0] got_q[$];
    logic        prev_valid = 1'b0, prev_xfer = 1'b0;
    logic [6:0]  prev_addr = 7'h00;
    logic [15:0] prev_data = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Volume register word from the attenuation rule: 1.5 dB steps, 0 means mute.
    function automatic logic [15:0] ref_vol(input int v);
        int a;
        if (v == 0) return 16'h8000;
        a = 30 - 2 * v;
        return 16'(a * 256 + a);
    endfunction

    always @(negedge clk) begin
        if (reset_b) begin
            if (prev_valid && !prev_xfer)
                check("hold_stable", 32'({cmd_valid, cmd_addr, cmd_data}), 32'({1'b1, prev_addr, prev_data}));
            if (cmd_valid && cmd_ready) got_q.push_back({cmd_addr, cmd_data});
            if (ext_ack) ack_cnt++;
        end
        prev_valid = cmd_valid;
        prev_xfer  = cmd_valid && cmd_ready;
        prev_addr  = cmd_addr;
        prev_data  = cmd_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ext_ack) ext_req = 1'b0;
        if (rdy_rand) cmd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_cmd(input string tag, input logic [6:0] a, input logic [15:0] d);
        logic [22:0] got;
        int n = 0;
        while (got_q.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        if (got_q.size() == 0) begin
            check({tag, "_timeout"}, 32'(got_q.size()), 32'd1);
        end else begin
            got = got_q.pop_front();
            check(tag, 32'(got), 32'({a, d}));
        end
    endtask

    task automatic vol_pair(input logic [3:0] v);
        expect_cmd("vol_master", 7'h02, ref_vol(int'(v)));
        expect_cmd("vol_hp", 7'h04, ref_vol(int'(v)));
        tb_last_vol = 1'b1;
        model_vol = v;
    endtask

    task automatic ext_one(input logic [6:0] a, input logic [15:0] d);
        expect_cmd("ext_cmd", a, d);
        exp_acks++;
        tb_last_vol = 1'b0;
    endtask

    task automatic request(input bit want_vol, input bit want_ext, input logic [3:0] v,
                           input logic [6:0] a, input logic [15:0] d);
        bit vol_first;
        if (want_vol) volume_control = v;
        if (want_ext) begin
            ext_addr = a;
            ext_data = d;
            ext_req  = 1'b1;
        end
        vol_first = want_vol && (!want_ext || !RR || !tb_last_vol);
        if (vol_first) begin
            vol_pair(v);
            if (want_ext) ext_one(a, d);
        end else begin
            if (want_ext) ext_one(a, d);
            if (want_vol) vol_pair(v);
        end
    endtask

    task automatic expect_init(input logic [3:0] v);
        expect_cmd("init0", 7'h00, 16'h0000);
        expect_cmd("init1", 7'h02, ref_vol(int'(v)));
        expect_cmd("init2", 7'h04, ref_vol(int'(v)));
        check("init_done_before_last", 32'(init_done), 32'd0);
        expect_cmd("init3", 7'h18, 16'h0808);
        check("init_done_after_last", 32'(init_done), 32'd1);
        model_vol = v;
    endtask

    initial begin
        int n;
        logic [3:0] v;
        int kind;

        repeat (3) @(negedge clk);
        check("rst_cmd", 32'({cmd_valid, cmd_addr, cmd_data}), 32'd0);
        check("rst_codec_reset_b", 32'(codec_reset_b), 32'd0);
        check("rst_flags", 32'({init_done, init_error, ext_ack}), 32'd0);
        @(posedge clk);
        #1 reset_b = 1'b1;

        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (codec_reset_b) break;
            n++;
        end
        check("hold_len", 32'(n), 32'(HOLD_N));
        check("err_before_timeout", 32'(init_error), 32'd0);

        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (!codec_reset_b) break;
            n++;
        end
        check("wait_len", 32'(n), 32'(TO_N));
        check("init_error_set", 32'(init_error), 32'd1);
        check("reset_reasserted", 32'(codec_reset_b), 32'd0);

        tick();
        codec_ready = 1'b1;
        n = 0;
        while (!cmd_valid && n < 100) begin
            tick();
            n++;
        end
        check("init_first_cmd", 32'({cmd_valid, cmd_addr, cmd_data}), 32'({1'b1, 7'h00, 16'h0000}));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("backpressure_cmd", 32'({cmd_valid, cmd_addr, cmd_data}), 32'({1'b1, 7'h02, 16'h0000}));
            tick();
        end
        rdy_rand = 1'b1;
        expect_init(4'hF);
        check("init_error_sticky", 32'(init_error), 32'd1);

        request(1'b1, 1'b0, 4'h0, 7'h00, 16'h0000);
        request(1'b1, 1'b0, 4'h8, 7'h00, 16'h0000);
        check("vol8_word", 32'(ref_vol(8)), 32'h0E0E);
        request(1'b1, 1'b1, 4'h3, 7'h1A, 16'h0404);

        for (int i = 0; i < 16; i++) begin
            kind = int'($urandom_range(0, 2));
            v = 4'($urandom_range(0, 15));
            if (v == model_vol) v = v + 4'd1;
            request(kind != 1, kind != 0, v, 7'($urandom_range(0, 127)), 16'($urandom));
        end

        repeat (3) tick();
        check("ack_count", 32'(ack_cnt), 32'(exp_acks));

        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        @(negedge clk);
        check("reinit_clears_done", 32'(init_done), 32'd0);
        check("reinit_holds_codec", 32'(codec_reset_b), 32'd0);
        expect_init(model_vol);
        check("init_error_after_reinit", 32'(init_error), 32'd1);

        repeat (5) tick();
        check("no_extra_cmds", 32'(got_q.size()), 32'd0);
        check("ack_count_final", 32'(ack_cnt), 32'(exp_acks));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
